insn_decoder: RTL and testbench

- Decode stage directly downstream of the instruction fetcher.
- Takes the fetched instruction word and its valid/stall handshake, and splits the word into opcode, register and immediate fields.
- Checks source registers against a register-busy scoreboard and holds the instruction while a hazard exists.
- Issues decoded instructions to the execute stage through a one-deep output register; writeback clears busy bits.

---
 rtl/insn_decoder_pkg.sv | 15 +
 rtl/insn_scoreboard.sv | 30 +++
 rtl/insn_decoder.sv | 76 +++++++
 tb/tb_insn_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/insn_decoder_pkg.sv
// insn_decoder_pkg: shared instruction-format widths, field positions and opcode constants
package insn_decoder_pkg;
    localparam int LEN_INSN     = 32;
    localparam int LEN_OPCODE   = 6;
    localparam int LEN_REG_ADDR = 5;
    localparam int NUM_REGS     = 32;
    localparam int LEN_IMM      = 16;
    localparam int OPCODE_LSB   = 26;
    localparam int RD_LSB       = 21;
    localparam int RS1_LSB      = 16;
    localparam int RS2_LSB      = 11;
    localparam int IMM_LSB      = 0;
    localparam int IMM_FLAG_BIT = 5;
    localparam logic [LEN_OPCODE-1:0] OP_NOP = '0;
endpackage

// File: rtl/insn_scoreboard.sv
// insn_scoreboard: register-busy vector with writeback clear, issue set and two bypassed read ports
module insn_scoreboard
    import insn_decoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_en,
    input  logic [LEN_REG_ADDR-1:0] clr_addr,
    input  logic                    set_en,
    input  logic [LEN_REG_ADDR-1:0] set_addr,
    input  logic [LEN_REG_ADDR-1:0] rd_a,
    input  logic [LEN_REG_ADDR-1:0] rd_b,
    output logic                    busy_a,
    output logic                    busy_b,
    output logic [NUM_REGS-1:0]     busy
);
    logic [NUM_REGS-1:0] clr_mask, set_mask, busy_eff;
    // a writeback in this cycle already counts as complete for the lookups
    always_comb begin
        clr_mask = clr_en ? NUM_REGS'(1) << clr_addr : '0;
        set_mask = set_en ? NUM_REGS'(1) << set_addr : '0;
        busy_eff = busy & ~clr_mask;
        busy_a   = busy_eff[rd_a];
        busy_b   = busy_eff[rd_b];
    end
    // clear then set so an issuing writer wins over its own old writeback; r0 never busy
    always_ff @(posedge clk or negedge rst)
        if (!rst) busy <= '0;
        else busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
endmodule

// File: rtl/insn_decoder.sv
// insn_decoder: field split, RAW hazard hold and one-deep issue register toward execute
module insn_decoder
    import insn_decoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [LEN_INSN-1:0]     insn_i,
    output logic                    stall_o,
    output logic                    valid_o,
    input  logic                    stall_i,
    output logic [LEN_OPCODE-1:0]   opcode_o,
    output logic [LEN_REG_ADDR-1:0] rd_o,
    output logic [LEN_REG_ADDR-1:0] rs1_o,
    output logic [LEN_REG_ADDR-1:0] rs2_o,
    output logic [LEN_INSN-1:0]     imm_o,
    output logic                    use_imm_o,
    input  logic                    wb_valid_i,
    input  logic [LEN_REG_ADDR-1:0] wb_addr_i,
    output logic [NUM_REGS-1:0]     busy_o
);
    logic [LEN_OPCODE-1:0]   op;
    logic [LEN_REG_ADDR-1:0] rd, rs1, rs2;
    logic [LEN_INSN-1:0]     imm;
    logic nop, reads_rs1, reads_rs2, writes_rd, busy1, busy2, hazard, issue, set_en;
    // classify the incoming word and decide hazard, issue and upstream stall
    always_comb begin
        op        = insn_i[OPCODE_LSB +: LEN_OPCODE];
        rd        = insn_i[RD_LSB +: LEN_REG_ADDR];
        rs1       = insn_i[RS1_LSB +: LEN_REG_ADDR];
        rs2       = insn_i[RS2_LSB +: LEN_REG_ADDR];
        imm       = {{(LEN_INSN-LEN_IMM){insn_i[IMM_LSB+LEN_IMM-1]}}, insn_i[IMM_LSB +: LEN_IMM]};
        nop       = op == OP_NOP;
        reads_rs1 = !nop;
        reads_rs2 = !nop && !op[IMM_FLAG_BIT];
        writes_rd = !nop && rd != '0;
        hazard    = valid_i && ((reads_rs1 && busy1) || (reads_rs2 && busy2));
        issue     = !(valid_o && stall_i);
        set_en    = issue && valid_i && !hazard && writes_rd;
        stall_o   = !issue || hazard;
    end
    insn_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (wb_valid_i),
        .clr_addr (wb_addr_i),
        .set_en   (set_en),
        .set_addr (rd),
        .rd_a     (rs1),
        .rd_b     (rs2),
        .busy_a   (busy1),
        .busy_b   (busy2),
        .busy     (busy_o)
    );
    // output register: hold under downstream stall, bubble on hazard, else latch the word
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            valid_o   <= 1'b0;
            opcode_o  <= '0;
            rd_o      <= '0;
            rs1_o     <= '0;
            rs2_o     <= '0;
            imm_o     <= '0;
            use_imm_o <= 1'b0;
        end else if (issue) begin
            valid_o <= valid_i && !hazard;
            if (!hazard) begin
                opcode_o  <= op;
                rd_o      <= rd;
                rs1_o     <= rs1;
                rs2_o     <= rs2;
                imm_o     <= imm;
                use_imm_o <= op[IMM_FLAG_BIT];
            end
        end
endmodule

// File: tb/tb_insn_decoder.sv
// tb_insn_decoder: scoreboard bench with directed and random stimulus against a reference model
module tb_insn_decoder;
    logic clk = 0, rst = 0, valid_i = 0, stall_i = 0, wb_valid_i = 0;
    logic [31:0] insn_i = 0;
    logic [4:0] wb_addr_i = 0;
    logic stall_o, valid_o, use_imm_o;
    logic [5:0] opcode_o;
    logic [4:0] rd_o, rs1_o, rs2_o;
    logic [31:0] imm_o, busy_o;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        ui;
    } rec_t;

    rec_t q[$];
    logic [31:0] m_busy = 0;
    bit m_valid = 0;
    int n_vec = 0, n_err = 0;

    insn_decoder dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .insn_i(insn_i), .stall_o(stall_o),
        .valid_o(valid_o), .stall_i(stall_i), .opcode_o(opcode_o), .rd_o(rd_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .use_imm_o(use_imm_o),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(int op, int rd, int rs1, int lo);
        return (op << 26) | (rd << 21) | (rs1 << 16) | (lo & 32'hFFFF);
    endfunction

    // one cycle: drive at negedge, check stall_o, predict the edge, check busy_o after it
    task automatic step(bit v, logic [31:0] w, bit st, bit wv, logic [4:0] wa);
        int op, rd, rs1, rs2;
        logic [31:0] eff;
        bit hz, nop;
        rec_t r;
        @(negedge clk);
        valid_i = v; insn_i = w; stall_i = st; wb_valid_i = wv; wb_addr_i = wa;
        #1;
        op  = int'(w >> 26);
        rd  = int'((w >> 21) % 32);
        rs1 = int'((w >> 16) % 32);
        rs2 = int'((w >> 11) % 32);
        eff = m_busy;
        if (wv) eff[wa] = 0;
        nop = op == 0;
        hz  = v && !nop && ((rs1 != 0 && eff[rs1]) || (op < 32 && rs2 != 0 && eff[rs2]));
        chk("stall_o", {31'b0, stall_o}, {31'b0, (m_valid && st) || hz});
        if (wv) m_busy[wa] = 0;
        if (!(m_valid && st)) begin
            if (hz) m_valid = 0;
            else begin
                m_valid = v;
                if (v) begin
                    r.op = 6'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
                    r.imm = 32'($signed(w[15:0]));
                    r.ui = op >= 32;
                    q.push_back(r);
                    if (!nop && rd != 0) m_busy[rd] = 1;
                end
            end
        end
        m_busy[0] = 0;
        @(posedge clk);
        #1;
        chk("busy_o", busy_o, m_busy);
    endtask

    // monitor: an item leaves the output register on an edge where valid_o & ~stall_i
    initial forever begin
        rec_t e;
        @(negedge clk);
        #1;
        if (rst && valid_o && !stall_i) begin
            if (q.size() == 0) chk("unexpected_valid_o", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("opcode_o", {26'b0, opcode_o}, {26'b0, e.op});
                chk("rd_o", {27'b0, rd_o}, {27'b0, e.rd});
                chk("rs1_o", {27'b0, rs1_o}, {27'b0, e.rs1});
                chk("rs2_o", {27'b0, rs2_o}, {27'b0, e.rs2});
                chk("imm_o", imm_o, e.imm);
                chk("use_imm_o", {31'b0, use_imm_o}, {31'b0, e.ui});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid_o", {31'b0, valid_o}, 32'd0);
        chk("reset_busy_o", busy_o, 32'd0);
        chk("reset_imm_o", imm_o, 32'd0);
        chk("reset_opcode_o", {26'b0, opcode_o}, 32'd0);
        @(negedge clk);
        rst = 1;
        // simple flow
        step(1, 32'h04221800, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // RAW on r1, released by a same-cycle writeback
        step(1, mk(2, 4, 1, 0), 0, 0, 0);
        step(1, mk(2, 4, 1, 0), 0, 0, 0);
        step(1, mk(2, 4, 1, 0), 0, 1, 1);
        step(1, mk(3, 6, 0, 4 << 11), 0, 1, 4);
        // immediate forms with r1 busy: rs2 field ignored
        step(1, mk(1, 1, 0, 0), 0, 0, 0);
        step(1, mk(6'h21, 7, 0, 16'h0800), 0, 0, 0);
        step(1, mk(6'h21, 8, 0, 16'hFFFE), 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 7);
        step(0, 0, 0, 1, 8);
        // downstream stall holds, bubble under stall is overwritten
        step(1, mk(1, 2, 0, 0), 0, 0, 0);
        repeat (3) step(1, mk(1, 3, 0, 0), 1, 0, 0);
        step(1, mk(1, 3, 0, 0), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, mk(1, 4, 0, 0), 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // set/clear collision on r5
        step(1, mk(1, 5, 0, 0), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, mk(1, 5, 0, 0), 0, 1, 5);
        step(0, 0, 0, 0, 0);
        // randomized traffic over a small register window to provoke hazards
        repeat (600) begin
            int op;
            op = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            step($urandom_range(0, 9) < 7,
                 mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'(($urandom_range(0, 7) << 11) | $urandom_range(0, 2047))),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)));
        end
        // asynchronous reset mid-stream with valid_o=1 and r3 busy
        step(1, mk(1, 3, 0, 0), 0, 1, 3);
        chk("pre_reset_valid_o", {31'b0, valid_o}, 32'd1);
        @(negedge clk);
        valid_i = 0; stall_i = 0; wb_valid_i = 0;
        rst = 0;
        #1;
        chk("async_valid_o", {31'b0, valid_o}, 32'd0);
        chk("async_busy_o", busy_o, 32'd0);
        q.delete();
        m_busy = 0;
        m_valid = 0;
        @(negedge clk);
        rst = 1;
        step(1, 32'h04221800, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
